// File: rtl/pool_2x2.sv
// pool_2x2: 2x2 stride-2 signed int8 max pooling, streamed over an ICB master port.
// Define POOL_RELU_EN to clamp negative pooled bytes to zero after the max.
module pool_2x2 #(
    parameter logic [31:0] SRC_ADDR = 32'h6000_0000,
    parameter logic [31:0] DST_ADDR = 32'h6001_0000,
    parameter int          CHN      = 16,
    parameter int          DIM      = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        done,
    output logic        busy,
    output logic        err,
    output logic        pool_icb_cmd_valid,
    input  logic        pool_icb_cmd_ready,
    output logic [31:0] pool_icb_cmd_addr,
    output logic        pool_icb_cmd_read,
    output logic [31:0] pool_icb_cmd_wdata,
    output logic [3:0]  pool_icb_cmd_wmask,
    input  logic        pool_icb_rsp_valid,
    output logic        pool_icb_rsp_ready,
    input  logic [31:0] pool_icb_rsp_rdata,
    input  logic        pool_icb_rsp_err
);
    localparam int OROWS = DIM / 2;
    localparam int OCOLS = DIM / 8;
    localparam int CH_W  = CHN > 1 ? $clog2(CHN) : 1;
    localparam int OR_W  = $clog2(OROWS);
    localparam int OC_W  = OCOLS > 1 ? $clog2(OCOLS) : 1;
    localparam logic [31:0] CH_BYTES   = 32'(DIM * DIM);
    localparam logic [31:0] ROW_BYTES  = 32'(DIM);
    localparam logic [31:0] OCH_BYTES  = 32'(OROWS * OROWS);
    localparam logic [31:0] OROW_BYTES = 32'(OROWS);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHN - 1);
    localparam logic [OR_W-1:0] OR_LAST = OR_W'(OROWS - 1);
    localparam logic [OC_W-1:0] OC_LAST = OC_W'(OCOLS - 1);

    typedef enum logic [2:0] {IDLE, RCMD, RRSP, WCMD, WRSP} state_t;

    state_t          state_q, state_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [OR_W-1:0] orow_q, orow_d;
    logic [OC_W-1:0] ocol_q, ocol_d;
    logic [1:0]      rd_idx_q, rd_idx_d;
    logic [3:0][31:0] buf_q, buf_d;
    logic            start_q;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic            cmd_read_q, cmd_read_d;
    logic [31:0]     cmd_addr_q, cmd_addr_d;
    logic [31:0]     cmd_wdata_q, cmd_wdata_d;
    logic            start_edge, cmd_hs, rsp_take, last_word;
    logic [31:0]     rd_addr, wr_addr;

    function automatic logic [7:0] smax(input logic [7:0] a, input logic [7:0] b);
        return $signed(a) > $signed(b) ? a : b;
    endfunction

    function automatic logic [7:0] pool4(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c, input logic [7:0] d);
        logic [7:0] m;
        m = smax(smax(a, b), smax(c, d));
`ifdef POOL_RELU_EN
        return m[7] ? 8'h00 : m;
`else
        return m;
`endif
    endfunction

    // Word k feeds output bytes 0/1, word k+1 feeds bytes 2/3; each byte pairs two columns over two rows.
    function automatic logic [31:0] pool_word(input logic [31:0] w0, input logic [31:0] w1,
                                              input logic [31:0] w2, input logic [31:0] w3);
        return {pool4(w2[31:24], w2[23:16], w3[31:24], w3[23:16]),
                pool4(w2[15:8],  w2[7:0],   w3[15:8],  w3[7:0]),
                pool4(w0[31:24], w0[23:16], w1[31:24], w1[23:16]),
                pool4(w0[15:8],  w0[7:0],   w1[15:8],  w1[7:0])};
    endfunction

    always_comb begin
        start_edge = start & ~start_q;
        cmd_hs     = cmd_valid_q & pool_icb_cmd_ready;
        rsp_take   = pool_icb_rsp_valid & (state_q == RRSP || state_q == WRSP);
        last_word  = ch_q == CH_LAST && orow_q == OR_LAST && ocol_q == OC_LAST;
        state_d    = state_q;
        ch_d       = ch_q;
        orow_d     = orow_q;
        ocol_d     = ocol_q;
        rd_idx_d   = rd_idx_q;
        buf_d      = buf_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q | (rsp_take & pool_icb_rsp_err);
        case (state_q)
            IDLE: if (start_edge) begin
                state_d  = RCMD;
                busy_d   = 1'b1;
                done_d   = 1'b0;
                err_d    = 1'b0;
                ch_d     = '0;
                orow_d   = '0;
                ocol_d   = '0;
                rd_idx_d = '0;
            end
            RCMD: state_d = cmd_hs ? RRSP : RCMD;
            RRSP: if (rsp_take) begin
                buf_d[rd_idx_q] = pool_icb_rsp_rdata;
                rd_idx_d        = rd_idx_q + 2'd1;
                state_d         = rd_idx_q == 2'd3 ? WCMD : RCMD;
            end
            WCMD: state_d = cmd_hs ? WRSP : WCMD;
            WRSP: if (rsp_take) begin
                rd_idx_d = '0;
                ocol_d   = ocol_q == OC_LAST ? '0 : ocol_q + 1'b1;
                orow_d   = ocol_q != OC_LAST ? orow_q : orow_q == OR_LAST ? '0 : orow_q + 1'b1;
                ch_d     = (ocol_q != OC_LAST || orow_q != OR_LAST) ? ch_q :
                           ch_q == CH_LAST ? '0 : ch_q + 1'b1;
                state_d  = last_word ? IDLE : RCMD;
                done_d   = last_word;
                busy_d   = ~last_word;
            end
            default: state_d = IDLE;
        endcase
        rd_addr     = SRC_ADDR + 32'(ch_d) * CH_BYTES + 32'({orow_d, rd_idx_d[0]}) * ROW_BYTES
                      + 32'({ocol_d, rd_idx_d[1]}) * 32'd4;
        wr_addr     = DST_ADDR + 32'(ch_d) * OCH_BYTES + 32'(orow_d) * OROW_BYTES
                      + 32'(ocol_d) * 32'd4;
        cmd_valid_d = state_d == RCMD || state_d == WCMD;
        cmd_read_d  = state_d == RCMD ? 1'b1 : state_d == WCMD ? 1'b0 : cmd_read_q;
        cmd_addr_d  = state_d == RCMD ? rd_addr : state_d == WCMD ? wr_addr : cmd_addr_q;
        cmd_wdata_d = state_d == WCMD ? pool_word(buf_d[0], buf_d[1], buf_d[2], buf_d[3]) : cmd_wdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            orow_q      <= '0;
            ocol_q      <= '0;
            rd_idx_q    <= '0;
            buf_q       <= '0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_read_q  <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            orow_q      <= orow_d;
            ocol_q      <= ocol_d;
            rd_idx_q    <= rd_idx_d;
            buf_q       <= buf_d;
            start_q     <= start;
            done_q      <= done_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_read_q  <= cmd_read_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
        end
    end

    assign done               = done_q;
    assign busy               = busy_q;
    assign err                = err_q;
    assign pool_icb_cmd_valid = cmd_valid_q;
    assign pool_icb_cmd_addr  = cmd_addr_q;
    assign pool_icb_cmd_read  = cmd_read_q;
    assign pool_icb_cmd_wdata = cmd_wdata_q;
    assign pool_icb_cmd_wmask = 4'b1111;
    assign pool_icb_rsp_ready = 1'b1;
endmodule

// File: tb/tb_pool_2x2.sv
// tb_pool_2x2: scoreboard bench for pool_2x2 with a memory-slave model and an image-level pooling reference.
// Build with POOL_RELU_EN defined identically for bench and design.
module tb_pool_2x2;
    localparam int CHN  = 16;
    localparam int DIM  = 32;
    localparam int NPIX = CHN * DIM * DIM;
    localparam int N_WR = CHN * (DIM / 2) * (DIM / 2) / 4;
    localparam int N_RD = 4 * N_WR;
    localparam logic [31:0] SRC = 32'h6000_0000;
    localparam logic [31:0] DST = 32'h6001_0000;

    logic        clk, rst, start;
    logic        done, busy, err;
    logic        cmd_valid, cmd_ready, cmd_read;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wmask;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    pool_2x2 dut (
        .clk(clk), .rst(rst), .start(start), .done(done), .busy(busy), .err(err),
        .pool_icb_cmd_valid(cmd_valid), .pool_icb_cmd_ready(cmd_ready),
        .pool_icb_cmd_addr(cmd_addr), .pool_icb_cmd_read(cmd_read),
        .pool_icb_cmd_wdata(cmd_wdata), .pool_icb_cmd_wmask(cmd_wmask),
        .pool_icb_rsp_valid(rsp_valid), .pool_icb_rsp_ready(rsp_ready),
        .pool_icb_rsp_rdata(rsp_rdata), .pool_icb_rsp_err(rsp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0]  src_mem [NPIX];
    logic [31:0] exp_rd[$];
    logic [63:0] exp_wr[$];
    int          n_cmp = 0, n_fail = 0;
    int          rd_cnt = 0, wr_cnt = 0, rd0 = 0, wr0 = 0;
    logic [31:0] last_rd_addr, first_wr_addr, first_wr_data, last_wr_addr, last_wr_data;
    bit          stall_en = 1'b0;
    int          slv_rd_num = 0, err_at = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        int o;
        if (a < SRC || a >= SRC + 32'(NPIX)) return 32'hDEAD_BEEF;
        o = int'(a - SRC);
        return {src_mem[o+3], src_mem[o+2], src_mem[o+1], src_mem[o]};
    endfunction

    task automatic set_word(input int off, input logic [31:0] w);
        for (int i = 0; i < 4; i++) src_mem[off+i] = w[8*i +: 8];
    endtask

    // Reference: pool the image directly as pixels; output column x takes input columns 2x and 2x+1.
    task automatic build_expect();
        exp_rd.delete();
        exp_wr.delete();
        for (int c = 0; c < CHN; c++)
            for (int r = 0; r < DIM / 2; r++)
                for (int k = 0; k < DIM / 8; k++) begin
                    logic [31:0] d;
                    int m, v;
                    byte sv;
                    d = '0;
                    for (int i = 0; i < 4; i++)
                        exp_rd.push_back(SRC + 32'(c * DIM * DIM + (2 * r + i % 2) * DIM + (2 * k + i / 2) * 4));
                    for (int b = 0; b < 4; b++) begin
                        m = -1000;
                        for (int dy = 0; dy < 2; dy++)
                            for (int dx = 0; dx < 2; dx++) begin
                                sv = byte'(src_mem[c * DIM * DIM + (2 * r + dy) * DIM + 2 * (4 * k + b) + dx]);
                                v  = sv;
                                if (v > m) m = v;
                            end
`ifdef POOL_RELU_EN
                        if (m < 0) m = 0;
`endif
                        d[8*b +: 8] = 8'(m);
                    end
                    exp_wr.push_back({DST + 32'(c * (DIM / 2) * (DIM / 2) + r * (DIM / 2) + k * 4), d});
                end
    endtask

    // Memory slave: one response per command, at least one cycle after the handshake.
    initial begin : slave
        logic        pend, hs_prev, hs_read, p_err;
        logic [31:0] hs_addr, p_rdata;
        int          dly;
        pend = 1'b0; hs_prev = 1'b0; hs_read = 1'b0; p_err = 1'b0;
        hs_addr = '0; p_rdata = '0; dly = 0;
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0; rsp_err = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                pend = 1'b0; hs_prev = 1'b0;
                cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0;
            end else begin
                if (rsp_valid) pend = 1'b0;
                if (hs_prev) begin
                    pend    = 1'b1;
                    dly     = stall_en ? int'($urandom_range(0, 1)) : 0;
                    p_rdata = hs_read ? mem_word(hs_addr) : 32'h0;
                    if (hs_read) slv_rd_num++;
                    p_err   = hs_read && slv_rd_num == err_at;
                end
                rsp_valid = pend && dly == 0;
                if (pend && dly > 0) dly--;
                rsp_rdata = rsp_valid ? p_rdata : $urandom;
                rsp_err   = rsp_valid ? p_err : 1'b0;
                cmd_ready = stall_en ? ($urandom_range(0, 4) != 0) : 1'b1;
                hs_prev   = cmd_valid && cmd_ready;
                hs_addr   = cmd_addr;
                hs_read   = cmd_read;
            end
        end
    end

    // Monitor: pops expectations on every command handshake and checks stall stability.
    initial begin : monitor
        logic        hold_prev;
        logic [31:0] p_addr, p_wdata;
        logic        p_read;
        logic [63:0] e;
        hold_prev = 1'b0; p_addr = '0; p_wdata = '0; p_read = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) hold_prev = 1'b0;
            else begin
                if (hold_prev) begin
                    check("hold_valid", 64'(cmd_valid), 64'd1);
                    check("hold_addr", 64'(cmd_addr), 64'(p_addr));
                    check("hold_rw_data", 64'({cmd_read, cmd_wdata}), 64'({p_read, p_wdata}));
                end
                if (cmd_valid && cmd_ready) begin
                    if (cmd_read) begin
                        rd_cnt++;
                        last_rd_addr = cmd_addr;
                        check("rd_expected", 64'(exp_rd.size() > 0), 64'd1);
                        if (exp_rd.size() > 0) check("rd_addr", 64'(cmd_addr), 64'(exp_rd.pop_front()));
                    end else begin
                        wr_cnt++;
                        if (wr_cnt == wr0 + 1) begin
                            first_wr_addr = cmd_addr;
                            first_wr_data = cmd_wdata;
                        end
                        last_wr_addr = cmd_addr;
                        last_wr_data = cmd_wdata;
                        check("wr_expected", 64'(exp_wr.size() > 0), 64'd1);
                        if (exp_wr.size() > 0) begin
                            e = exp_wr.pop_front();
                            check("wr_addr", 64'(cmd_addr), 64'(e[63:32]));
                            check("wr_data", 64'(cmd_wdata), 64'(e[31:0]));
                        end
                    end
                end
                hold_prev = cmd_valid && !cmd_ready;
                p_addr = cmd_addr; p_wdata = cmd_wdata; p_read = cmd_read;
            end
        end
    end

    task automatic launch();
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        first_wr_addr = '0;
        first_wr_data = '0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check("busy_on_start", 64'(busy), 64'd1);
        check("done_cleared", 64'(done), 64'd0);
        check("err_cleared", 64'(err), 64'd0);
        start = 1'b0;
    endtask

    task automatic finish_run(input int budget, input logic exp_err);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_set", 64'(done), 64'd1);
        check("busy_clear", 64'(busy), 64'd0);
        check("err_flag", 64'(err), 64'(exp_err));
        check("read_count", 64'(rd_cnt - rd0), 64'(N_RD));
        check("write_count", 64'(wr_cnt - wr0), 64'(N_WR));
        check("wr_left", 64'(exp_wr.size()), 64'd0);
    endtask

    initial begin : main
        int n;
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        check("rst_cmd_read", 64'(cmd_read), 64'd0);
        check("rst_cmd_addr", 64'(cmd_addr), 64'd0);
        check("rst_cmd_wdata", 64'(cmd_wdata), 64'd0);
        check("rst_flags", 64'({done, busy, err}), 64'd0);
        check("wmask_rsp_ready", 64'({cmd_wmask, rsp_ready}), 64'h1F);
        rst = 1'b0;

        for (int i = 0; i < NPIX; i++) src_mem[i] = 8'h00;
        build_expect();
        launch();
        finish_run(12000, 1'b0);
        check("zero_last_addr", 64'(last_wr_addr), 64'h6001_0FFC);
        check("zero_last_data", 64'(last_wr_data), 64'h0);

        for (int i = 0; i < NPIX; i++) src_mem[i] = 8'($urandom);
        set_word(0, 32'h0403_0201);
        set_word(DIM, 32'h0807_0605);
        set_word(4, 32'h0C0B_0A09);
        set_word(DIM + 4, 32'h100F_0E0D);
        build_expect();
        launch();
        finish_run(12000, 1'b0);
        check("first_wr_addr", 64'(first_wr_addr), 64'h6001_0000);
        check("first_wr_data", 64'(first_wr_data), 64'h100E_0806);

        stall_en = 1'b1;
        build_expect();
        launch();
        repeat (500) @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("busy_after_midrun_start", 64'(busy), 64'd1);
        start = 1'b0;
        finish_run(40000, 1'b0);
        check("stall_first_wr", 64'(first_wr_data), 64'h100E_0806);
        stall_en = 1'b0;

        for (int i = 0; i < NPIX; i++) src_mem[i] = 8'h80;
        build_expect();
        launch();
        finish_run(12000, 1'b0);
`ifdef POOL_RELU_EN
        check("neg_last_data", 64'(last_wr_data), 64'h0000_0000);
`else
        check("neg_last_data", 64'(last_wr_data), 64'h8080_8080);
`endif

        build_expect();
        err_at = slv_rd_num + 5;
        launch();
        finish_run(12000, 1'b1);
        err_at = -1;

        build_expect();
        launch();
        n = 0;
        while (!(wr_cnt - wr0 == 100 && cmd_valid && !cmd_read) && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("reach_word100", 64'(wr_cnt - wr0), 64'd100);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_cmd_valid", 64'(cmd_valid), 64'd0);
        check("abort_busy_done", 64'({busy, done}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_after_abort", 64'({cmd_valid, busy}), 64'd0);

        build_expect();
        launch();
        n = 0;
        while (rd_cnt == rd0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("restart_first_addr", 64'(last_rd_addr), 64'h6000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
